// File: rtl/uart_tx_fifo_drain_if.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_drain_if
//   Read-side bundle between a byte FIFO and its UART drain.
//   fifo_empty : FIFO empty flag               (FIFO -> drain)
//   fifo_data  : FIFO data_out, DW bits        (FIFO -> drain), valid the cycle after a pop
//   fifo_ren   : FIFO read enable, 1-cycle pulse per word (drain -> FIFO)
//   modport master : the drain (drives fifo_ren)
//   modport slave  : the FIFO  (drives fifo_empty / fifo_data)
// ----------------------------------------------------------------------------
interface uart_tx_fifo_drain_if #(
    parameter int DW = 8
) ();
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_ren;

    modport master (
        output fifo_ren,
        input  fifo_empty,
        input  fifo_data
    );

    modport slave (
        input  fifo_ren,
        output fifo_empty,
        output fifo_data
    );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_drain
//   Pops one word from the FIFO whenever it is non-empty and transmit is
//   enabled, then serialises it LSB first onto a UART line as 8N1, or 8E1
//   when PARITY_EN=1.
// Parameters
//   DW           : data word width (matches FIFO)
//   CLKS_PER_BIT : clk cycles per UART bit, >= 2
//   PARITY_EN    : 1 = even-parity bit after the data bits
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   i_tx_en : gates new pops only; a frame in progress always completes
//   fifo    : FIFO read side (master modport: fifo_ren out, empty/data in)
//   o_tx    : registered UART line, idles high
//   o_busy  : high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module uart_tx_fifo_drain #(
    parameter int DW           = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_tx_en,
    uart_tx_fifo_drain_if.master        fifo,
    output logic                        o_tx,
    output logic                        o_busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(DW + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DW - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    logic [2:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [CW-1:0] r_bit;
    logic [DW-1:0] r_shift;
    logic          r_par;
    logic          r_tx;

    logic          w_fifo_ren;
    logic          w_baud_last;
    logic          w_bit_last;

    // Gated by rst so that the reset-value IDLE state cannot pop while the
    // block is still held in reset.
    assign w_fifo_ren  = (r_state == S_IDLE) & i_tx_en & ~fifo.fifo_empty & ~rst;
    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_bit_last  = (r_bit == BIT_LAST);

    assign fifo.fifo_ren = w_fifo_ren;
    assign o_tx          = r_tx;
    assign o_busy        = (r_state != S_IDLE);

    // r_tx is loaded from the current state's line value, so the line lags
    // the state register by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_fifo_ren) begin
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_tx    <= 1'b1;
                    r_shift <= fifo.fifo_data;
                    r_par   <= 1'b0;
                    r_state <= S_START;
                end

                S_START: begin
                    r_tx <= 1'b0;
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end

                S_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        // Parity accumulates at each bit boundary, so it is
                        // complete by the time PARITY is entered.
                        r_par   <= r_par ^ r_shift[0];
                        if (w_bit_last) begin
                            r_bit   <= '0;
                            r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit <= r_bit + CW'(1);
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end

                S_PARITY: begin
                    r_tx <= r_par;
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end

                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo_drain
//   Directed bench for uart_tx_fifo_drain with DW=8, CLKS_PER_BIT=4.
//   dut0: PARITY_EN=0, dut1: PARITY_EN=1. Each has its own FIFO model
//   (a queue whose data_out is registered on the pop edge).
//   Cycle index k=0 is the cycle in which fifo_ren is expected high.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo_drain;

    logic clk = 1'b0;
    logic rst;
    logic tx_en0, tx_en1;
    logic tx0, tx1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    logic s_tx0, s_ren0, s_busy0;
    logic s_tx1, s_ren1, s_busy1;

    uart_tx_fifo_drain_if #(.DW(8)) f0 ();
    uart_tx_fifo_drain_if #(.DW(8)) f1 ();

    uart_tx_fifo_drain #(.DW(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .i_tx_en (tx_en0),
        .fifo    (f0),
        .o_tx    (tx0),
        .o_busy  (busy0)
    );

    uart_tx_fifo_drain #(.DW(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .i_tx_en (tx_en1),
        .fifo    (f1),
        .o_tx    (tx1),
        .o_busy  (busy1)
    );

    always #5 clk = ~clk;

    // Expected line value k cycles after the pop cycle (CLKS_PER_BIT=4):
    // two high cycles (IDLE, LOAD) plus one cycle of register lag, then
    // start, 8 data bits LSB first, optional even parity, stop, idle high.
    function automatic logic exp_tx(input logic [7:0] w, input bit pe, input int k);
        int idx;
        if (k < 3) return 1'b1;
        idx = (k - 3) / 4;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        if (pe && idx == 9) return ^w;
        return 1'b1;
    endfunction

    // busy covers LOAD plus the (2+8+pe)*4 frame cycles.
    function automatic logic exp_busy(input bit pe, input int k);
        return (k >= 1) && (k <= 1 + (10 + (pe ? 1 : 0)) * 4);
    endfunction

    // One clock cycle: sample mid-cycle, then model the FIFO pop edge.
    task automatic step();
        @(negedge clk);
        s_tx0 = tx0; s_ren0 = f0.fifo_ren; s_busy0 = busy0;
        s_tx1 = tx1; s_ren1 = f1.fifo_ren; s_busy1 = busy1;
        @(posedge clk);
        #1;
        if (s_ren0) begin
            if (q0.size() != 0) f0.fifo_data = q0.pop_front();
            f0.fifo_empty = (q0.size() == 0);
        end
        if (s_ren1) begin
            if (q1.size() != 0) f1.fifo_data = q1.pop_front();
            f1.fifo_empty = (q1.size() == 0);
        end
    endtask

    task automatic push0(input logic [7:0] w);
        q0.push_back(w);
        f0.fifo_empty = 1'b0;
    endtask

    task automatic push1(input logic [7:0] w);
        q1.push_back(w);
        f1.fifo_empty = 1'b0;
    endtask

    task automatic test_reset();
        push0(8'hA5);
        push1(8'h07);
        push1(8'h03);
        tx_en0 = 1'b1;
        tx_en1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks += 6;
            if (s_tx0 !== 1'b1)  begin errors++; $display("FAIL reset_tx0 cycle %0d: got %b expected 1", k, s_tx0); end
            if (s_busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 cycle %0d: got %b expected 0", k, s_busy0); end
            if (s_ren0 !== 1'b0) begin errors++; $display("FAIL reset_ren0 cycle %0d: got %b expected 0", k, s_ren0); end
            if (s_tx1 !== 1'b1)  begin errors++; $display("FAIL reset_tx1 cycle %0d: got %b expected 1", k, s_tx1); end
            if (s_busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 cycle %0d: got %b expected 0", k, s_busy1); end
            if (s_ren1 !== 1'b0) begin errors++; $display("FAIL reset_ren1 cycle %0d: got %b expected 0", k, s_ren1); end
        end
        tx_en1 = 1'b0;
        rst    = 1'b0;
    endtask

    // First cycle after reset release must already pop 0xA5.
    task automatic test_single_word();
        int ren_count = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (s_ren0) ren_count++;
            checks += 4;
            if (s_ren0 !== (k == 0)) begin errors++; $display("FAIL single_ren cycle %0d: got %b expected %b", k, s_ren0, (k == 0)); end
            if (s_tx0 !== exp_tx(8'hA5, 1'b0, k)) begin errors++; $display("FAIL single_tx cycle %0d: got %b expected %b", k, s_tx0, exp_tx(8'hA5, 1'b0, k)); end
            if (s_busy0 !== exp_busy(1'b0, k)) begin errors++; $display("FAIL single_busy cycle %0d: got %b expected %b", k, s_busy0, exp_busy(1'b0, k)); end
            if (s_ren1 !== 1'b0) begin errors++; $display("FAIL single_ren1_idle cycle %0d: got %b expected 0", k, s_ren1); end
        end
        checks++;
        if (ren_count != 1) begin errors++; $display("FAIL single_ren_count: got %0d expected 1", ren_count); end
    endtask

    // Second pop lands in the IDLE cycle right after the stop bit (k=42);
    // line is high at k=43,44 and the second start bit shows at k=45.
    task automatic test_back_to_back();
        push0(8'h00);
        push0(8'hFF);
        for (int k = 0; k < 90; k++) begin
            logic et, eb;
            step();
            et = (k < 42) ? exp_tx(8'h00, 1'b0, k) : exp_tx(8'hFF, 1'b0, k - 42);
            eb = (k < 42) ? exp_busy(1'b0, k) : exp_busy(1'b0, k - 42);
            checks += 3;
            if (s_ren0 !== (k == 0 || k == 42)) begin errors++; $display("FAIL b2b_ren cycle %0d: got %b expected %b", k, s_ren0, (k == 0 || k == 42)); end
            if (s_tx0 !== et) begin errors++; $display("FAIL b2b_tx cycle %0d: got %b expected %b", k, s_tx0, et); end
            if (s_busy0 !== eb) begin errors++; $display("FAIL b2b_busy cycle %0d: got %b expected %b", k, s_busy0, eb); end
        end
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL b2b_fifo_drained: got %0d words left expected 0", q0.size()); end
    endtask

    // 0x07 -> parity 1 at k=39..42; 0x03 -> parity 0; 44-cycle frames, so
    // the second pop is at k=46.
    task automatic test_parity();
        tx_en1 = 1'b1;
        for (int k = 0; k < 96; k++) begin
            logic et, eb;
            step();
            et = (k < 46) ? exp_tx(8'h07, 1'b1, k) : exp_tx(8'h03, 1'b1, k - 46);
            eb = (k < 46) ? exp_busy(1'b1, k) : exp_busy(1'b1, k - 46);
            checks += 3;
            if (s_ren1 !== (k == 0 || k == 46)) begin errors++; $display("FAIL par_ren cycle %0d: got %b expected %b", k, s_ren1, (k == 0 || k == 46)); end
            if (s_tx1 !== et) begin errors++; $display("FAIL par_tx cycle %0d: got %b expected %b", k, s_tx1, et); end
            if (s_busy1 !== eb) begin errors++; $display("FAIL par_busy cycle %0d: got %b expected %b", k, s_busy1, eb); end
            if (k == 40) begin
                checks++;
                if (s_tx1 !== 1'b1) begin errors++; $display("FAIL par_bit_07: got %b expected 1", s_tx1); end
            end
            if (k == 86) begin
                checks++;
                if (s_tx1 !== 1'b0) begin errors++; $display("FAIL par_bit_03: got %b expected 0", s_tx1); end
            end
        end
        tx_en1 = 1'b0;
    endtask

    // Reset asserted during data bit 3 of 0x5A (state DATA bit 3 spans k=18..21).
    task automatic test_reset_mid_frame();
        push0(8'h5A);
        push0(8'h3C);
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (s_tx0 !== exp_tx(8'h5A, 1'b0, k)) begin errors++; $display("FAIL midrst_pre_tx cycle %0d: got %b expected %b", k, s_tx0, exp_tx(8'h5A, 1'b0, k)); end
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks += 3;
            if (s_tx0 !== 1'b1)  begin errors++; $display("FAIL midrst_tx cycle %0d: got %b expected 1", k, s_tx0); end
            if (s_busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy cycle %0d: got %b expected 0", k, s_busy0); end
            if (s_ren0 !== 1'b0) begin errors++; $display("FAIL midrst_ren cycle %0d: got %b expected 0", k, s_ren0); end
        end
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            checks += 3;
            if (s_ren0 !== (k == 0)) begin errors++; $display("FAIL midrst_post_ren cycle %0d: got %b expected %b", k, s_ren0, (k == 0)); end
            if (s_tx0 !== exp_tx(8'h3C, 1'b0, k)) begin errors++; $display("FAIL midrst_post_tx cycle %0d: got %b expected %b", k, s_tx0, exp_tx(8'h3C, 1'b0, k)); end
            if (s_busy0 !== exp_busy(1'b0, k)) begin errors++; $display("FAIL midrst_post_busy cycle %0d: got %b expected %b", k, s_busy0, exp_busy(1'b0, k)); end
        end
    endtask

    task automatic test_tx_en();
        tx_en0 = 1'b0;
        push0(8'h11);
        push0(8'h22);
        for (int k = 0; k < 100; k++) begin
            step();
            checks += 3;
            if (s_ren0 !== 1'b0) begin errors++; $display("FAIL txen_off_ren cycle %0d: got %b expected 0", k, s_ren0); end
            if (s_busy0 !== 1'b0) begin errors++; $display("FAIL txen_off_busy cycle %0d: got %b expected 0", k, s_busy0); end
            if (s_tx0 !== 1'b1) begin errors++; $display("FAIL txen_off_tx cycle %0d: got %b expected 1", k, s_tx0); end
        end
        tx_en0 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            checks += 3;
            if (s_ren0 !== (k == 0)) begin errors++; $display("FAIL txen_drop_ren cycle %0d: got %b expected %b", k, s_ren0, (k == 0)); end
            if (s_tx0 !== exp_tx(8'h11, 1'b0, k)) begin errors++; $display("FAIL txen_drop_tx cycle %0d: got %b expected %b", k, s_tx0, exp_tx(8'h11, 1'b0, k)); end
            if (s_busy0 !== exp_busy(1'b0, k)) begin errors++; $display("FAIL txen_drop_busy cycle %0d: got %b expected %b", k, s_busy0, exp_busy(1'b0, k)); end
            if (k == 9) tx_en0 = 1'b0;
        end
        checks++;
        if (q0.size() != 1) begin errors++; $display("FAIL txen_words_left: got %0d expected 1", q0.size()); end
    endtask

    initial begin
        rst           = 1'b1;
        tx_en0        = 1'b0;
        tx_en1        = 1'b0;
        f0.fifo_empty = 1'b1;
        f0.fifo_data  = '0;
        f1.fifo_empty = 1'b1;
        f1.fifo_data  = '0;

        test_reset();
        test_single_word();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        test_tx_en();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
